// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the snake game datapath blocks.
//   - Screen coordinate widths and limits.
//   - Game phase encoding used by target_hit_tracker.
//   - Default winning score.
//   - Helper that compares a head position with a target position.
package snake_pkg;

  localparam int H_W           = 8;
  localparam int V_W           = 7;
  localparam int H_MAX         = 160;
  localparam int V_MAX         = 120;
  localparam int WIN_SCORE_DEF = 30;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PLAY   = 3'd1,
    ST_HIT    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_WIN    = 3'd4
  } state_t;

  // A hit needs every coordinate bit to agree.
  function automatic logic coord_match(input logic [H_W-1:0] ah,
                                       input logic [V_W-1:0] av,
                                       input logic [H_W-1:0] bh,
                                       input logic [V_W-1:0] bv);
    return (ah == bh) && (av == bv);
  endfunction

endpackage

// File: rtl/target_hit_tracker_pulse_stretcher.sv
// pulse_stretcher: turns a one-cycle load strobe into a level that stays high
// for HOLD cycles, starting the cycle after the load.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset; drops the level at once
//   load   in   one-cycle strobe; (re)starts the hold window
//   level  out  registered stretched output
//   last   out  high during the final cycle of the hold window
module pulse_stretcher #(
  parameter int HOLD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic level,
  output logic last
);

  localparam logic [3:0] LOAD_VAL = 4'(HOLD - 1);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      level <= 1'b1;
      cnt   <= LOAD_VAL;
    end else if (level) begin
      if (cnt == 4'd0) begin
        level <= 1'b0;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign last = level && (cnt == 4'd0);

endmodule

// File: rtl/target_hit_tracker.sv
// target_hit_tracker: compares the snake head with the current target on each
// movement tick. A hit raises REACHED for REACHED_HOLD cycles (feeding the
// target generator), pulses GROW once and bumps SCORE. A phase FSM
// (idle / play / hit / settle / win) keeps a stale target from being scored
// twice and gives the generator one settle cycle to present the new target.
//
// Optional build macro TARGET_TIMEOUT_EN: a target left unhit for
// TIMEOUT_TICKS movement ticks is forcibly relocated by a REACHED pulse that
// neither scores nor grows the snake.
//
// Ports:
//   CLK        in   system clock
//   RESET      in   asynchronous active-low reset
//   START      in   level; begins a game from idle or win
//   MOVE_TICK  in   strobe; head position valid this cycle
//   HEAD_H/V   in   head coordinates
//   TARGET_H/V in   current target coordinates
//   REACHED    out  stretched hit pulse to the target generator
//   GROW       out  one-cycle body growth request
//   SCORE      out  hits this game (saturating)
//   PLAYING    out  high in play and hit phases
//   WIN        out  high in win phase
module target_hit_tracker
  import snake_pkg::*;
#(
  parameter int SCORE_W       = 8,
  parameter int WIN_SCORE     = WIN_SCORE_DEF,
  parameter int REACHED_HOLD  = 4,
  parameter int TIMEOUT_TICKS = 200
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic               MOVE_TICK,
  input  logic [H_W-1:0]     HEAD_H,
  input  logic [V_W-1:0]     HEAD_V,
  input  logic [H_W-1:0]     TARGET_H,
  input  logic [V_W-1:0]     TARGET_V,
  output logic               REACHED,
  output logic               GROW,
  output logic [SCORE_W-1:0] SCORE,
  output logic               PLAYING,
  output logic               WIN
);

  generate
    if (REACHED_HOLD < 2 || REACHED_HOLD > 15 || TIMEOUT_TICKS < 1 ||
        WIN_SCORE < 1 || WIN_SCORE >= (1 << SCORE_W)) begin : g_bad_params
      $error("target_hit_tracker: illegal parameter combination");
    end
  endgenerate

  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t state;
  logic   hit;
  logic   load;
  logic   hold_last;

  // Compare only on a tick in PLAY; ticks in other phases see a stale target.
  assign hit = (state == ST_PLAY) && MOVE_TICK &&
               coord_match(HEAD_H, HEAD_V, TARGET_H, TARGET_V);

`ifdef TARGET_TIMEOUT_EN
  localparam int             TO_W    = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

  logic [TO_W-1:0] to_cnt;
  logic            timeout;

  // The tick that would make the count reach TIMEOUT_TICKS forces relocation.
  assign timeout = (state == ST_PLAY) && MOVE_TICK && !hit && (to_cnt == TO_LAST);
  assign load    = hit || timeout;

  // Held at zero outside PLAY, so it is clear on every entry into PLAY.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      to_cnt <= '0;
    end else if (state != ST_PLAY) begin
      to_cnt <= '0;
    end else if (MOVE_TICK) begin
      if (hit || timeout) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end
`else
  assign load = hit;
`endif

  pulse_stretcher #(
    .HOLD (REACHED_HOLD)
  ) u_reached (
    .clk   (CLK),
    .rst_n (RESET),
    .load  (load),
    .level (REACHED),
    .last  (hold_last)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= ST_IDLE;
      GROW    <= 1'b0;
      SCORE   <= '0;
      PLAYING <= 1'b0;
      WIN     <= 1'b0;
    end else begin
      GROW <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            state   <= ST_PLAY;
            SCORE   <= '0;
            PLAYING <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (hit) begin
            state <= ST_HIT;
            GROW  <= 1'b1;
            if (SCORE != SCORE_MAX) begin
              SCORE <= SCORE + 1'b1;
            end
`ifdef TARGET_TIMEOUT_EN
          end else if (timeout) begin
            state <= ST_HIT;
`endif
          end
        end
        ST_HIT: begin
          // Leave together with REACHED falling.
          if (hold_last) begin
            PLAYING <= 1'b0;
            if (SCORE == WIN_VAL) begin
              state <= ST_WIN;
              WIN   <= 1'b1;
            end else begin
              state <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          state   <= ST_PLAY;
          PLAYING <= 1'b1;
        end
        ST_WIN: begin
          if (START) begin
            state   <= ST_PLAY;
            SCORE   <= '0;
            WIN     <= 1'b0;
            PLAYING <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          PLAYING <= 1'b0;
          WIN     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_target_hit_tracker.sv
// Directed bench for target_hit_tracker (WIN_SCORE=3, REACHED_HOLD=4,
// TIMEOUT_TICKS=5). Builds with or without TARGET_TIMEOUT_EN.
module tb_target_hit_tracker;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       START = 1'b0;
  logic       MOVE_TICK = 1'b0;
  logic [7:0] HEAD_H = '0;
  logic [6:0] HEAD_V = '0;
  logic [7:0] TARGET_H = '0;
  logic [6:0] TARGET_V = '0;
  logic       REACHED;
  logic       GROW;
  logic [7:0] SCORE;
  logic       PLAYING;
  logic       WIN;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef TARGET_TIMEOUT_EN
  localparam int NO_MATCH_TICKS = 4;
  localparam int EXP_TO_REACHED = 4;
`else
  localparam int NO_MATCH_TICKS = 50;
  localparam int EXP_TO_REACHED = 0;
`endif

  always #5 CLK = ~CLK;

  target_hit_tracker #(
    .SCORE_W       (8),
    .WIN_SCORE     (3),
    .REACHED_HOLD  (4),
    .TIMEOUT_TICKS (5)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .MOVE_TICK (MOVE_TICK),
    .HEAD_H    (HEAD_H),
    .HEAD_V    (HEAD_V),
    .TARGET_H  (TARGET_H),
    .TARGET_V  (TARGET_V),
    .REACHED   (REACHED),
    .GROW      (GROW),
    .SCORE     (SCORE),
    .PLAYING   (PLAYING),
    .WIN       (WIN)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    START = 1'b0;
    MOVE_TICK = 1'b0;
    repeat (2) step();
    RESET = 1'b1;
    step();
  endtask

  task automatic start_game();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic set_pos(input int hh, input int hv, input int th, input int tv);
    HEAD_H = 8'(hh);
    HEAD_V = 7'(hv);
    TARGET_H = 8'(th);
    TARGET_V = 7'(tv);
  endtask

  task automatic tick();
    MOVE_TICK = 1'b1;
    step();
    MOVE_TICK = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    START = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({REACHED, GROW, PLAYING, WIN} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {REACHED, GROW, PLAYING, WIN});
    end
    n_checks++;
    if (SCORE !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_score: got %0d expected 0", SCORE);
    end
    START = 1'b0;
    RESET = 1'b1;
    repeat (2) step();
    n_checks++;
    if (PLAYING !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: PLAYING got %b expected 0", PLAYING);
    end
  endtask

  task automatic test_basic_hit();
    int r;
    int g;
    do_reset();
    start_game();
    n_checks++;
    if (PLAYING !== 1'b1 || SCORE !== 8'd0) begin
      n_fail++;
      $display("FAIL start_play: PLAYING/SCORE got %b/%0d expected 1/0", PLAYING, SCORE);
    end
    set_pos(10, 5, 10, 5);
    tick();
    n_checks++;
    if ({REACHED, GROW, PLAYING} !== 3'b111 || SCORE !== 8'd1) begin
      n_fail++;
      $display("FAIL hit_latency: R/G/P got %b score %0d expected 111 score 1",
               {REACHED, GROW, PLAYING}, SCORE);
    end
    r = 1;
    g = 1;
    repeat (7) begin
      step();
      r += int'(REACHED);
      g += int'(GROW);
    end
    n_checks++;
    if (r !== 4) begin
      n_fail++;
      $display("FAIL reached_len: got %0d cycles expected 4", r);
    end
    n_checks++;
    if (g !== 1) begin
      n_fail++;
      $display("FAIL grow_len: got %0d cycles expected 1", g);
    end
    n_checks++;
    if (SCORE !== 8'd1) begin
      n_fail++;
      $display("FAIL hit_score: got %0d expected 1", SCORE);
    end
  endtask

  task automatic test_no_match();
    int r;
    do_reset();
    start_game();
    // Match present only between ticks must be ignored.
    set_pos(10, 5, 10, 5);
    repeat (2) step();
    set_pos(10, 5, 10, 6);
    r = 0;
    for (int i = 0; i < NO_MATCH_TICKS; i++) begin
      tick();
      r += int'(REACHED);
      step();
      r += int'(REACHED);
    end
    repeat (3) begin
      step();
      r += int'(REACHED);
    end
    n_checks++;
    if (r !== 0) begin
      n_fail++;
      $display("FAIL no_match_reached: got %0d high cycles expected 0", r);
    end
    n_checks++;
    if (SCORE !== 8'd0 || PLAYING !== 1'b1) begin
      n_fail++;
      $display("FAIL no_match_score: score/PLAYING got %0d/%b expected 0/1", SCORE, PLAYING);
    end
  endtask

  task automatic test_stale_ticks();
    int  rises;
    logic prev;
    do_reset();
    start_game();
    set_pos(20, 7, 20, 7);
    MOVE_TICK = 1'b1;
    step();
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (REACHED && !prev) rises++;
      prev = REACHED;
      if (i == 2) MOVE_TICK = 1'b0;
      step();
    end
    n_checks++;
    if (rises !== 1) begin
      n_fail++;
      $display("FAIL stale_rises: got %0d rising edges expected 1", rises);
    end
    n_checks++;
    if (SCORE !== 8'd1) begin
      n_fail++;
      $display("FAIL stale_score: got %0d expected 1", SCORE);
    end
  endtask

  task automatic test_win();
    do_reset();
    start_game();
    for (int k = 1; k <= 3; k++) begin
      set_pos(30 + k, 10, 30 + k, 10);
      tick();
      n_checks++;
      if (SCORE !== 8'(k)) begin
        n_fail++;
        $display("FAIL win_score_step: got %0d expected %0d", SCORE, k);
      end
      repeat (5) step();
      if (k < 3) begin
        n_checks++;
        if (WIN !== 1'b0 || PLAYING !== 1'b1) begin
          n_fail++;
          $display("FAIL win_early: WIN/PLAYING got %b/%b expected 0/1", WIN, PLAYING);
        end
      end
    end
    n_checks++;
    if ({WIN, PLAYING, REACHED} !== 3'b100 || SCORE !== 8'd3) begin
      n_fail++;
      $display("FAIL win_state: W/P/R got %b score %0d expected 100 score 3",
               {WIN, PLAYING, REACHED}, SCORE);
    end
    set_pos(50, 10, 50, 10);
    tick();
    step();
    n_checks++;
    if (SCORE !== 8'd3 || REACHED !== 1'b0 || WIN !== 1'b1) begin
      n_fail++;
      $display("FAIL win_frozen: score/R/W got %0d/%b/%b expected 3/0/1", SCORE, REACHED, WIN);
    end
    start_game();
    n_checks++;
    if (SCORE !== 8'd0 || WIN !== 1'b0 || PLAYING !== 1'b1) begin
      n_fail++;
      $display("FAIL win_restart: score/W/P got %0d/%b/%b expected 0/0/1", SCORE, WIN, PLAYING);
    end
  endtask

  task automatic test_reset_mid_hit();
    do_reset();
    start_game();
    set_pos(10, 5, 10, 5);
    tick();
    step();
    n_checks++;
    if (REACHED !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_hit_pre: REACHED got %b expected 1", REACHED);
    end
    RESET = 1'b0;
    #1;
    n_checks++;
    if (REACHED !== 1'b0 || SCORE !== 8'd0 || PLAYING !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: R/score/P got %b/%0d/%b expected 0/0/0", REACHED, SCORE, PLAYING);
    end
    #2;
    RESET = 1'b1;
    tick();
    step();
    n_checks++;
    if (REACHED !== 1'b0 || SCORE !== 8'd0 || PLAYING !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_mid_reset: R/score/P got %b/%0d/%b expected 0/0/0",
               REACHED, SCORE, PLAYING);
    end
  endtask

  task automatic test_timeout();
    int r;
    int g;
    do_reset();
    start_game();
    set_pos(10, 5, 10, 6);
    r = 0;
    g = 0;
    for (int i = 0; i < 20; i++) begin
      MOVE_TICK = (i < 10) && (i % 2 == 0);
      step();
      MOVE_TICK = 1'b0;
      r += int'(REACHED);
      g += int'(GROW);
    end
    n_checks++;
    if (r !== EXP_TO_REACHED) begin
      n_fail++;
      $display("FAIL timeout_reached: got %0d cycles expected %0d", r, EXP_TO_REACHED);
    end
    n_checks++;
    if (g !== 0 || SCORE !== 8'd0) begin
      n_fail++;
      $display("FAIL timeout_no_score: grow/score got %0d/%0d expected 0/0", g, SCORE);
    end
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_no_match();
    test_stale_ticks();
    test_win();
    test_reset_mid_hit();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
